// File: rtl/myproject_dense_accum.sv
// ---------------------------------------------------------------------------
// myproject_dense_accum
//
// Dense-layer accumulator for the anomaly-detector datapath. Sums N_IN signed
// products from the upstream multiplier on top of a pre-aligned per-neuron
// bias, requantizes the sum with an arithmetic right shift, saturates it to a
// signed OUT_WIDTH activation and offers one result per frame downstream.
//
// Optional build macro:
//   MYPROJECT_DENSE_ACCUM_RELU_EN - negative requantized values become 0
//                                   (not flagged as saturated).
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   ce          clock enable; all state and outputs hold while low
//   prod_valid  product present on prod_data
//   prod_data   signed product (PROD_WIDTH)
//   prod_ready  product can be accepted (IDLE/ACCUM)
//   bias        signed bias, sampled on the first product of a frame
//   out_valid   out_data/out_sat hold a result
//   out_ready   downstream accepts the result
//   out_data    signed requantized activation (OUT_WIDTH)
//   out_sat     result was clipped
// ---------------------------------------------------------------------------
module myproject_dense_accum #(
    parameter int N_IN       = 16,
    parameter int PROD_WIDTH = 26,
    parameter int BIAS_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int FRAC_SHIFT = 10,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  prod_valid,
    input  logic [PROD_WIDTH-1:0] prod_data,
    output logic                  prod_ready,
    input  logic [BIAS_WIDTH-1:0] bias,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_sat
);

    localparam int CNT_W = $clog2(N_IN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);

    // Clip bounds expressed at accumulator width; the minimum is the bitwise
    // complement of the maximum in two's complement.
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = ACC_WIDTH'((longint'(1) <<< (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = ~OUT_MAX;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        ROUND,
        HOLD
    } state_t;

    state_t                        state;
    state_t                        state_nxt;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic        [CNT_W-1:0]       cnt;

    logic                          in_xfer;
    logic                          out_xfer;
    logic signed [ACC_WIDTH-1:0]   prod_sext;
    logic signed [ACC_WIDTH-1:0]   bias_aligned;
    logic signed [ACC_WIDTH-1:0]   shifted;
    logic signed [ACC_WIDTH-1:0]   relu_val;
    logic        [OUT_WIDTH-1:0]   rq_data;
    logic                          rq_sat;

    assign prod_ready = (state == IDLE) || (state == ACCUM);
    assign in_xfer    = prod_valid & prod_ready & ce;
    assign out_xfer   = out_valid & out_ready & ce;

    assign prod_sext    = ACC_WIDTH'($signed(prod_data));
    assign bias_aligned = ACC_WIDTH'($signed(bias)) <<< FRAC_SHIFT;

    // acc is signed, so >>> floors toward -inf.
    assign shifted = acc >>> FRAC_SHIFT;

    // NOTE: every signal driven in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        relu_val = shifted;
`ifdef MYPROJECT_DENSE_ACCUM_RELU_EN
        if (shifted < 0) begin
            relu_val = '0;
        end
`endif
        rq_sat  = 1'b0;
        rq_data = relu_val[OUT_WIDTH-1:0];
        if (relu_val > OUT_MAX) begin
            rq_data = OUT_MAX[OUT_WIDTH-1:0];
            rq_sat  = 1'b1;
        end else if (relu_val < OUT_MIN) begin
            rq_data = OUT_MIN[OUT_WIDTH-1:0];
            rq_sat  = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_xfer) state_nxt = (N_IN == 1) ? ROUND : ACCUM;
            ACCUM:   if (in_xfer && (cnt == CNT_LAST)) state_nxt = ROUND;
            ROUND:   if (ce) state_nxt = HOLD;
            HOLD:    if (out_xfer) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else if (ce) begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (ce) begin
            case (state)
                IDLE: begin
                    if (in_xfer) begin
                        acc <= bias_aligned + prod_sext;
                        cnt <= CNT_W'(1);
                    end
                end
                ACCUM: begin
                    if (in_xfer) begin
                        acc <= acc + prod_sext;
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ROUND: begin
                    out_data  <= rq_data;
                    out_sat   <= rq_sat;
                    out_valid <= 1'b1;
                end
                HOLD: begin
                    if (out_xfer) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/myproject_dense_accum.md
Name: myproject_dense_accum

Overview:
- Downstream consumer of the 2-stage signed product multiplier (16s x 10s -> 26-bit product) in the dense-layer datapath of the anomaly-detector network.
- Accumulates N_IN consecutive signed products plus a per-neuron bias into a wide accumulator.
- Requantizes the sum by an arithmetic right shift and saturates it to a 16-bit signed activation.
- Presents one neuron output per frame over a valid/ready handshake to the next layer.

Parameters:
- N_IN, 16, number of products accumulated per output (>=1)
- PROD_WIDTH, 26, width of incoming signed product
- BIAS_WIDTH, 16, width of signed bias
- ACC_WIDTH, 32, accumulator width (>= PROD_WIDTH + clog2(N_IN) + 1)
- FRAC_SHIFT, 10, arithmetic right shift applied at requantization; bias is pre-aligned by the same shift
- OUT_WIDTH, 16, signed output width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- ce  in  1  clock enable; when 0 all state, counters and outputs hold
- prod_valid  in  1  product present on prod_data
- prod_data  in  PROD_WIDTH  signed product from the multiplier
- prod_ready  out  1  block can accept a product (combinational from state)
- bias  in  BIAS_WIDTH  signed bias, sampled on the first accepted product of a frame
- out_valid  out  1  out_data holds a result
- out_ready  in  1  downstream accepts the result
- out_data  out  OUT_WIDTH  signed requantized activation
- out_sat  out  1  result was clipped, valid with out_valid

Behaviour:
- Input transfer = prod_valid & prod_ready & ce. Output transfer = out_valid & out_ready & ce.
- FSM states: IDLE, ACCUM, ROUND, HOLD. prod_ready=1 in IDLE/ACCUM, 0 in ROUND/HOLD.
- IDLE, on transfer: acc <= (sext(bias) <<< FRAC_SHIFT) + sext(prod_data); cnt <= 1.
  - Next state ACCUM, or ROUND if N_IN==1.
- ACCUM, on transfer: acc <= acc + sext(prod_data); cnt <= cnt+1.
  - When cnt==N_IN-1 at the transfer, go to ROUND. Without a transfer, stay in ACCUM.
- ROUND (exactly one ce cycle):
  - s = acc >>> FRAC_SHIFT (arithmetic, truncation toward -inf).
  - Clip s to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Register the result into out_data; out_sat <= clipped; out_valid <= 1; go to HOLD.
- HOLD: out_data, out_sat and out_valid stay stable until output transfer. Then out_valid <= 0 and go to IDLE.
- No input is accepted in the same cycle as the output transfer; the next frame starts on the following cycle.
- Latency: last product accepted at edge t -> out_valid high after edge t+1 (2 ce cycles). Throughput: one output per N_IN+2 cycles with out_ready held at 1.
- Accumulation wraps in two's complement; no saturation inside acc. ACC_WIDTH sizing guarantees no wrap for legal ranges.
- ce=0: no transfers, no state change, outputs frozen. This includes mid-frame and during ROUND.
- Reset, including mid-frame or in HOLD: state=IDLE, acc=0, cnt=0, out_valid=0, out_data=0, out_sat=0.
  - Any partial sum is discarded. prod_ready=1 on the first cycle after reset.
- bias is ignored except on the first transfer of a frame.

Optional Feature:
- Macro: MYPROJECT_DENSE_ACCUM_RELU_EN.
- Defined: in ROUND, s<0 is forced to 0 before clipping; out_sat is 0 for the negative case. Upper clipping is unchanged.
- Undefined: linear output; negative values are clipped symmetrically as above.

Test Plan (defaults except N_IN=4; FRAC_SHIFT=10):
- Basic sum: bias=0, products 1024, 2048, -1024, 3072 back-to-back, out_ready=1 -> out_data=5, out_sat=0, out_valid 2 cycles after the 4th product, one cycle wide.
- Negative: bias=0, 4 x -2048 -> out_data=-8 (0xFFF8) without RELU_EN; 0 with RELU_EN; out_sat=0.
- Saturation: bias=30000, 4 x 1048576 -> pre-clip 34096 -> out_data=32767, out_sat=1. bias=-30000, 4 x -1048576 -> -32768, out_sat=1 (0, out_sat=0 with RELU_EN).
- Backpressure and stall:
  - Hold out_ready=0 for 5 cycles after out_valid -> out_data stable, prod_ready=0, further prod_valid ignored. Release -> single transfer, then the next frame.
  - Drop ce for 3 cycles mid-ACCUM -> result identical to the unstalled run.
- Reset mid-frame: accept 2 products (1024 each), assert reset 1 cycle, then feed 4 x 1024 with bias=0 -> out_data=4. No stale output; out_valid low during and after reset until the new frame completes.
- N_IN=1 build: each product p=5120, bias=0 -> out_data=5 per product; with out_ready=1, one result every 3 cycles.
